pacman_dl_ctrl: RTL and testbench

//  Sequences the HPS ioctl download stream into the Pacman-family core: routes ROM bytes to the core memory write port, latches the game-variant byte and DIP bytes, and holds the core in reset during and after ROM load.

---
 rtl/pacman_pkg.sv | 33 +++
 rtl/pacman_wr_arb.sv | 56 +++++
 rtl/pacman_dl_ctrl.sv | 129 ++++++++++++
 tb/tb_pacman_dl_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared types and constants for the Pacman-family download controller.
// Hiscore write-port sharing is enabled by defining PACMAN_HISCORE_EN.
package pacman_pkg;

  typedef enum logic [1:0] {
    S_DL,
    S_SETTLE,
    S_RUN
  } dl_state_t;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

  localparam logic [7:0] MOD_PACMAN   = 8'd0;
  localparam logic [7:0] MOD_MSPACMAN = 8'd1;
  localparam logic [7:0] MOD_PUCKMAN  = 8'd2;
  localparam logic [7:0] MOD_MRTNT    = 8'd3;
  localparam logic [7:0] MOD_WOODPECK = 8'd4;
  localparam logic [7:0] MOD_EYES     = 8'd5;
  localparam logic [7:0] MOD_GORKANS  = 8'd6;
  localparam logic [7:0] MOD_LIZWIZ   = 8'd7;
  localparam logic [7:0] MOD_PONPOKO  = 8'd8;
  localparam logic [7:0] MOD_VANVAN   = 8'd9;
  localparam logic [7:0] MOD_BIRDIY   = 8'd10;
  localparam logic [7:0] MOD_ALIBABA  = 8'd11;
  localparam logic [7:0] MOD_CROSSBOW = 8'd12;
  localparam logic [7:0] MOD_DREAMSHR = 8'd13;
  localparam logic [7:0] MOD_EGGOR    = 8'd14;
  localparam logic [7:0] MOD_JUMPSHOT = 8'd15;
  localparam logic [7:0] MOD_SHOOTBUL = 8'd16;

endpackage

// File: rtl/pacman_wr_arb.sv
// Registered priority mux for the core memory write port.
// PACMAN_HISCORE_EN adds the hiscore requester behind the download path.
import pacman_pkg::*;

module pacman_wr_arb #(
  parameter int ADDR_W = 16
) (
  input  logic              clk_sys,
  input  logic              RESET,
  input  logic              hs_en,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  input  logic              hs_req,
  input  logic [ADDR_W-1:0] hs_addr,
  input  logic [7:0]        hs_wdata,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              hs_ack
);

  logic hs_gnt;

`ifdef PACMAN_HISCORE_EN
  assign hs_gnt = hs_en & hs_req & ~dl_wr;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) hs_ack <= 1'b0;
    else       hs_ack <= hs_gnt;
  end
`else
  logic unused_hs;
  assign unused_hs = ^{hs_en, hs_req, hs_addr, hs_wdata};
  assign hs_gnt    = 1'b0;
  assign hs_ack    = 1'b0;
`endif

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      mem_wr <= dl_wr | hs_gnt;
      if (dl_wr) begin
        mem_addr <= dl_addr;
        mem_data <= dl_data;
      end else if (hs_gnt) begin
        mem_addr <= hs_addr;
        mem_data <= hs_wdata;
      end
    end
  end

endmodule

// File: rtl/pacman_dl_ctrl.sv
// ioctl download sequencer: ROM routing, variant/DIP latches, core reset.
// Hiscore sharing of the write port is enabled by PACMAN_HISCORE_EN.
import pacman_pkg::*;

module pacman_dl_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int SETTLE_CYC = 16,
  parameter int NUM_MODS   = 17
) (
  input  logic                clk_sys,
  input  logic                RESET,
  input  logic                ext_reset,
  input  logic                ioctl_download,
  input  logic                ioctl_wr,
  input  logic [7:0]          ioctl_index,
  input  logic [24:0]         ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  input  logic                hs_req,
  input  logic [ADDR_W-1:0]   hs_addr,
  input  logic [7:0]          hs_wdata,
  output logic                hs_ack,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [7:0]          mem_data,
  output logic                core_reset,
  output logic [NUM_MODS-1:0] mod_onehot,
  output logic [63:0]         dip_sw,
  output logic                busy
);

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC);

  dl_state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [7:0] mod_sel;
  logic [NUM_MODS-1:0] mod_dec;
  logic rom_wr, mod_wr, dip_wr;

  assign rom_wr = ioctl_wr
               && (ioctl_index == IDX_ROM)
               && (ioctl_addr[24:ADDR_W] == '0);
  assign mod_wr = ioctl_wr && (ioctl_index == IDX_MOD);
  assign dip_wr = ioctl_wr
               && (ioctl_index == IDX_DIP)
               && (ioctl_addr[24:3] == '0);

  assign busy = (state != S_RUN);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (ioctl_download && (ioctl_index == IDX_ROM)) begin
      state_nx = S_DL;
    end else begin
      unique case (state)
        S_DL: begin
          if (!ioctl_download) begin
            state_nx = S_SETTLE;
            cnt_nx   = SETTLE_LD;
          end
        end
        S_SETTLE: begin
          if (cnt == 8'd0) state_nx = S_RUN;
          else             cnt_nx   = cnt - 8'd1;
        end
        S_RUN: ;
        default: begin
          state_nx = S_SETTLE;
          cnt_nx   = SETTLE_LD;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state      <= S_SETTLE;
      cnt        <= SETTLE_LD;
      core_reset <= 1'b1;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      core_reset <= (state != S_RUN) | ext_reset;
    end
  end

  // Out-of-range variant ids fall back to variant 0.
  always_comb begin
    mod_dec = '0;
    if (int'(mod_sel) < NUM_MODS) begin
      for (int i = 0; i < NUM_MODS; i++)
        if (int'(mod_sel) == i) mod_dec[i] = 1'b1;
    end else begin
      mod_dec[0] = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      mod_sel    <= MOD_PACMAN;
      mod_onehot <= {{(NUM_MODS-1){1'b0}}, 1'b1};
      dip_sw     <= '1;
    end else begin
      if (mod_wr) mod_sel <= ioctl_dout;
      mod_onehot <= mod_dec;
      if (dip_wr)
        dip_sw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
    end
  end

  pacman_wr_arb #(
    .ADDR_W(ADDR_W)
  ) u_arb (
    .clk_sys  (clk_sys),
    .RESET    (RESET),
    .hs_en    (state == S_RUN),
    .dl_wr    (rom_wr),
    .dl_addr  (ioctl_addr[ADDR_W-1:0]),
    .dl_data  (ioctl_dout),
    .hs_req   (hs_req),
    .hs_addr  (hs_addr),
    .hs_wdata (hs_wdata),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .hs_ack   (hs_ack)
  );

endmodule

// File: tb/tb_pacman_dl_ctrl.sv
// Self-checking bench for pacman_dl_ctrl.
// Hiscore checks are built when PACMAN_HISCORE_EN is defined.
module tb_pacman_dl_ctrl;

  localparam int AW = 16;
  localparam int SC = 16;
  localparam int NM = 17;

  logic          clk_sys = 1'b0;
  logic          RESET;
  logic          ext_reset;
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [7:0]    ioctl_index;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          hs_req;
  logic [AW-1:0] hs_addr;
  logic [7:0]    hs_wdata;
  logic          hs_ack;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          core_reset;
  logic [NM-1:0] mod_onehot;
  logic [63:0]   dip_sw;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  pacman_dl_ctrl #(
    .ADDR_W(AW), .SETTLE_CYC(SC), .NUM_MODS(NM)
  ) dut (
    .clk_sys(clk_sys), .RESET(RESET), .ext_reset(ext_reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .hs_req(hs_req), .hs_addr(hs_addr),
    .hs_wdata(hs_wdata), .hs_ack(hs_ack), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .core_reset(core_reset), .mod_onehot(mod_onehot),
    .dip_sw(dip_sw), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic count_hi(output int hi);
    hi = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (core_reset) hi++;
      else break;
    end
  endtask

  task automatic dl_byte(input logic [7:0] idx, input logic [24:0] a,
                         input logic [7:0] d);
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_wr    = 1'b1;
    tick();
    ioctl_wr    = 1'b0;
  endtask

  function automatic logic [NM-1:0] dec(input int v);
    return (v < NM) ? (17'd1 << v) : 17'd1;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr"}, 64'(mem_wr), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_data"}, 64'(mem_data), 64'd0);
    chk({tag, "_ack"}, 64'(hs_ack), 64'd0);
    chk({tag, "_cr"}, 64'(core_reset), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_mod"}, 64'(mod_onehot), 64'd1);
    chk({tag, "_dip"}, dip_sw, 64'hFFFF_FFFF_FFFF_FFFF);
  endtask

  logic [24:0] a;
  logic [7:0]  d;
  logic [63:0] dip_m;
  int          hi, v1, v2, found, pb1, pb2;
  logic        ok;

  initial begin
    RESET = 1'b1;
    ext_reset = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_index = 8'd0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    hs_req = 1'b0;
    hs_addr = '0;
    hs_wdata = '0;
    dip_m = '1;
    repeat (3) tick();
    chk_reset_vals("rst");

    RESET = 1'b0;
    count_hi(hi);
    chk("rst_settle", 64'(hi), 64'(SC + 1));
    chk("run_busy", 64'(busy), 64'd0);

    ioctl_download = 1'b1;
    ioctl_index = 8'd0;
    tick();
    chk("dl_entry_cr", 64'(core_reset), 64'd0);
    chk("dl_entry_busy", 64'(busy), 64'd1);
    tick();
    chk("dl_cr", 64'(core_reset), 64'd1);
    for (int i = 0; i < 16384; i++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = 8'(i);
      tick();
      chk("rom_wr", 64'(mem_wr), 64'd1);
      chk("rom_addr", 64'(mem_addr), 64'(i));
      chk("rom_data", 64'(mem_data), 64'(i & 255));
      chk("rom_cr", 64'(core_reset), 64'd1);
    end
    ioctl_wr = 1'b0;
    tick();
    chk("rom_idle", 64'(mem_wr), 64'd0);
    dl_byte(8'd0, 25'h10000, 8'hAB);
    chk("rom_oor", 64'(mem_wr), 64'd0);

    for (int i = 0; i < 400; i++) begin
      ok = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1)
        a = 25'($urandom_range(0, 65535));
      else
        a = 25'($urandom) | (25'd1 << $urandom_range(16, 24));
      d = 8'($urandom);
      ioctl_wr = ok;
      ioctl_addr = a;
      ioctl_dout = d;
      ok = ok && (a[24:16] == 9'd0);
      tick();
      chk("rnd_rom_wr", 64'(mem_wr), 64'(ok));
      if (ok) begin
        chk("rnd_rom_addr", 64'(mem_addr), 64'(a[15:0]));
        chk("rnd_rom_data", 64'(mem_data), 64'(d));
      end
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    tick();
    chk("dl_fall_busy", 64'(busy), 64'd1);
    chk("dl_fall_cr", 64'(core_reset), 64'd1);
    count_hi(hi);
    chk("dl_settle", 64'(hi), 64'(SC + 1));

    ioctl_download = 1'b1;
    dl_byte(8'd254, 25'd3, 8'h5A);
    dip_m[31:24] = 8'h5A;
    chk("dip3", dip_sw, 64'hFFFF_FFFF_5AFF_FFFF);
    chk("dip_cr", 64'(core_reset), 64'd0);
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1)
        a = 25'($urandom_range(0, 7));
      else
        a = 25'($urandom) | (25'd1 << $urandom_range(3, 24));
      d = 8'($urandom);
      if (a[24:3] == 22'd0) dip_m[8 * int'(a[2:0]) +: 8] = d;
      dl_byte(8'd254, a, d);
      chk("rnd_dip", dip_sw, dip_m);
      chk("rnd_dip_cr", 64'(core_reset), 64'd0);
    end
    ioctl_download = 1'b0;
    tick();

    ioctl_download = 1'b1;
    dl_byte(8'd1, 25'd0, 8'd5);
    tick();
    chk("mod5", 64'(mod_onehot), 64'h00020);
    dl_byte(8'd1, 25'd0, 8'd20);
    tick();
    chk("mod20", 64'(mod_onehot), 64'h00001);
    for (int i = 0; i < 8; i++) begin
      v1 = $urandom_range(0, 40);
      v2 = $urandom_range(0, 40);
      dl_byte(8'd1, 25'd0, 8'(v1));
      dl_byte(8'd1, 25'd0, 8'(v2));
      chk("mod_lat", 64'(mod_onehot), 64'(dec(v1)));
      tick();
      chk("mod_last", 64'(mod_onehot), 64'(dec(v2)));
      chk("mod_cr", 64'(core_reset), 64'd0);
    end
    ioctl_download = 1'b0;
    tick();

    ext_reset = 1'b1;
    tick();
    chk("ext_cr", 64'(core_reset), 64'd1);
    chk("ext_busy", 64'(busy), 64'd0);

`ifdef PACMAN_HISCORE_EN
    hs_req = 1'b1;
    hs_addr = 16'h4C80;
    hs_wdata = 8'h99;
    tick();
    chk("hs_ack", 64'(hs_ack), 64'd1);
    chk("hs_wr", 64'(mem_wr), 64'd1);
    chk("hs_addr", 64'(mem_addr), 64'h4C80);
    chk("hs_data", 64'(mem_data), 64'h99);
    for (int i = 0; i < 6; i++) begin
      a = 25'($urandom_range(0, 65535));
      d = 8'($urandom);
      hs_addr = a[15:0];
      hs_wdata = d;
      tick();
      chk("hs_b2b_ack", 64'(hs_ack), 64'd1);
      chk("hs_b2b_addr", 64'(mem_addr), 64'(a[15:0]));
      chk("hs_b2b_data", 64'(mem_data), 64'(d));
    end
    hs_req = 1'b0;
    tick();
    chk("hs_drop_ack", 64'(hs_ack), 64'd0);
    chk("hs_drop_wr", 64'(mem_wr), 64'd0);
    ext_reset = 1'b0;
    tick();
    tick();
    chk("ext_rel_cr", 64'(core_reset), 64'd0);

    ioctl_index = 8'd0;
    ioctl_addr = 25'h0123;
    ioctl_dout = 8'h77;
    ioctl_wr = 1'b1;
    hs_req = 1'b1;
    hs_addr = 16'h4C81;
    hs_wdata = 8'h42;
    tick();
    ioctl_wr = 1'b0;
    chk("pri_rom_wr", 64'(mem_wr), 64'd1);
    chk("pri_rom_addr", 64'(mem_addr), 64'h0123);
    chk("pri_rom_data", 64'(mem_data), 64'h77);
    chk("pri_rom_ack", 64'(hs_ack), 64'd0);
    tick();
    chk("pri_hs_ack", 64'(hs_ack), 64'd1);
    chk("pri_hs_addr", 64'(mem_addr), 64'h4C81);
    chk("pri_hs_data", 64'(mem_data), 64'h42);
    hs_req = 1'b0;
    tick();
    chk("pri_idle", 64'(mem_wr), 64'd0);

    ioctl_download = 1'b1;
    tick();
    hs_req = 1'b1;
    hs_addr = 16'h4C90;
    hs_wdata = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hs_dl_wait", 64'(hs_ack), 64'd0);
    end
    ioctl_download = 1'b0;
    found = 0;
    pb1 = 1;
    pb2 = 1;
    for (int k = 0; k < 100; k++) begin
      pb2 = pb1;
      pb1 = int'(busy);
      tick();
      if (hs_ack) begin
        found = 1;
        break;
      end
    end
    chk("hs_dl_found", 64'(found), 64'd1);
    chk("hs_dl_run", 64'(pb1), 64'd0);
    chk("hs_dl_first", 64'(pb2), 64'd1);
    chk("hs_dl_addr", 64'(mem_addr), 64'h4C90);
    chk("hs_dl_data", 64'(mem_data), 64'h3C);
    hs_req = 1'b0;
    tick();
    chk("hs_dl_drop", 64'(hs_ack), 64'd0);
`else
    hs_req = 1'b1;
    hs_addr = 16'h4C80;
    hs_wdata = 8'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nohs_ack", 64'(hs_ack), 64'd0);
      chk("nohs_wr", 64'(mem_wr), 64'd0);
    end
    hs_req = 1'b0;
    ext_reset = 1'b0;
    tick();
    tick();
    chk("ext_rel_cr", 64'(core_reset), 64'd0);
`endif

    ioctl_download = 1'b1;
    ioctl_index = 8'd0;
    tick();
    tick();
    dl_byte(8'd0, 25'h0042, 8'h17);
    chk("r6_wr", 64'(mem_wr), 64'd1);
    ioctl_addr = 25'h0043;
    ioctl_dout = 8'h18;
    ioctl_wr = 1'b1;
    #2;
    RESET = 1'b1;
    #1;
    chk_reset_vals("r6_async");
    ioctl_wr = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    tick();
    chk("r6_busy", 64'(busy), 64'd1);
    chk("r6_cr", 64'(core_reset), 64'd1);
    repeat (25) tick();
    chk("r6_held", 64'(core_reset), 64'd1);
    dl_byte(8'd0, 25'h0044, 8'h19);
    chk("r6_rom_wr", 64'(mem_wr), 64'd1);
    chk("r6_rom_addr", 64'(mem_addr), 64'h0044);
    chk("r6_rom_data", 64'(mem_data), 64'h19);
    ioctl_download = 1'b0;
    tick();
    count_hi(hi);
    chk("r6_settle", 64'(hi), 64'(SC + 1));
    chk("r6_mod", 64'(mod_onehot), 64'd1);
    chk("r6_dip", dip_sw, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
